// File: rtl/gb_master_arbiter_pkg.sv
// Shared types and sizing helpers for the ghostbus master arbiter.
package gb_master_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ACK     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } gb_state_t;

    localparam int STAT_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wait counter only ever holds READ_DELAY-1 down to 0.
    function automatic int cnt_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/gb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module gb_master_arbiter_rr_pick
    import gb_master_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    index,
    output logic             any
);

    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        j     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = IW'((int'(ptr) + i) % N_REQ);
            if (!any && req[j]) begin
                any      = 1'b1;
                index    = j;
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_master_arbiter.sv
// Round-robin arbiter sharing one ghostbus master port between N_REQ requesters.
// Optional GB_ARB_STATS_EN adds transaction / contention counters.
module gb_master_arbiter
    import gb_master_arbiter_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int READ_DELAY = 3
) (
    input  logic                gb_clk,
    input  logic                gb_rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                busy,
    output logic [AW-1:0]       gb_addr,
    output logic [DW-1:0]       gb_wdata,
    output logic                gb_wen,
    output logic                gb_rstb,
    input  logic [DW-1:0]       gb_rdata
`ifdef GB_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_xact,
    output logic [STAT_W-1:0]   stat_contend
`endif
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = cnt_width(READ_DELAY);

    gb_state_t         state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     idx_r;
    logic [CW-1:0]     cnt;
    logic              we_r;

    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_index;
    logic              pick_any;
    logic [IW-1:0]     rr_next;
    logic [N_REQ-1:0]  rsp_hot;

    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic              sel_we;

    gb_master_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_index == IW'(i)) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_we    = req_we[i];
            end
        end
    end

    assign rr_next   = (pick_index == IW'(N_REQ - 1)) ? '0 : pick_index + 1'b1;
    assign rsp_hot   = N_REQ'(1) << idx_r;
    // Accept is combinational so the requester sees it in the grant cycle itself.
    assign req_ready = (gb_rst_n && state == ST_IDLE) ? pick_grant : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            idx_r     <= '0;
            cnt       <= '0;
            we_r      <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gb_addr  <= sel_addr;
                        gb_wdata <= sel_wdata;
                        we_r     <= sel_we;
                        gb_wen   <= sel_we;
                        gb_rstb  <= ~sel_we;
                        idx_r    <= pick_index;
                        rr_ptr   <= rr_next;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gb_wen  <= 1'b0;
                    gb_rstb <= 1'b0;
                    if (we_r) begin
                        rsp_valid <= rsp_hot;
                        state     <= ST_ACK;
                    end else begin
                        cnt   <= CW'(READ_DELAY - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_ACK: begin
                    rsp_valid <= '0;
                    state     <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata <= gb_rdata;
                        rsp_valid <= rsp_hot;
                        state     <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    rsp_valid <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GB_ARB_STATS_EN
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            stat_xact    <= '0;
            stat_contend <= '0;
        end else begin
            if (state == ST_ACK || state == ST_CAPTURE)
                stat_xact <= stat_xact + 1'b1;
            if (state == ST_IDLE && pick_any && $countones(req_valid) > 1)
                stat_contend <= stat_contend + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gb_master_arbiter.sv
// Self-checking bench for gb_master_arbiter: schedule-based reference model plus ghostbus slave.
module tb_gb_master_arbiter;

    localparam int N    = 2;
    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int RD   = 3;
    localparam int MAXC = 6000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic [AW-1:0]   gb_addr;
    logic [DW-1:0]   gb_wdata;
    logic            gb_wen;
    logic            gb_rstb;
    logic [DW-1:0]   gb_rdata = '0;
`ifdef GB_ARB_STATS_EN
    logic [31:0]     stat_xact;
    logic [31:0]     stat_contend;
`endif

    gb_master_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .READ_DELAY(RD)) dut (
        .gb_clk(clk), .gb_rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
        .gb_rdata(gb_rdata)
`ifdef GB_ARB_STATS_EN
        , .stat_xact(stat_xact), .stat_contend(stat_contend)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } rq_t;
    typedef struct { int t; logic [AW-1:0] a; } srd_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit            e_wen [MAXC];
    bit            e_rstb[MAXC];
    bit            e_busy[MAXC];
    bit            e_rdchk[MAXC];
    bit            e_wchk[MAXC];
    logic [N-1:0]  e_rsp [MAXC];
    logic [AW-1:0] e_addr[MAXC];
    logic [DW-1:0] e_wdata[MAXC];
    logic [DW-1:0] e_rdata[MAXC];

    int rr = 0, free_at = 0, rd_lo = -1, rd_hi = -1;
    int m_xact = 0, m_cont = 0;
    logic [DW-1:0] m_last = '0;
    logic [DW-1:0] mmem [logic [AW-1:0]];
    logic [DW-1:0] smem [logic [AW-1:0]];
    rq_t  q[N][$];
    int   gap[N];
    srd_t s_q[$];
    bit   rand_mode = 0;
    bit   rst_req = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return 32'hA500_0000 ^ {8'h00, a};
    endfunction

    function automatic rq_t rand_rq();
        rq_t r;
        r.we   = 1'($urandom_range(0, 1));
        r.addr = AW'($urandom_range(0, 15) * 4);
        r.data = DW'($urandom);
        return r;
    endfunction

    function automatic rq_t mk(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_t r;
        r.we = we; r.addr = a; r.data = d;
        return r;
    endfunction

    task automatic step();
        int g;
        int nv;
        logic [N-1:0] rdy_exp;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = rst_req;

        gb_rdata = DW'($urandom);
        if (s_q.size() > 0 && s_q[0].t + RD == cyc) begin
            gb_rdata = smem.exists(s_q[0].a) ? smem[s_q[0].a] : dflt(s_q[0].a);
            s_q.delete(0);
        end

        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                if (gap[i] > 0) gap[i]--;
                if (q[i].size() > 0 && $urandom_range(0, 39) == 0) q[i].delete(0);
                if (q[i].size() == 0) q[i].push_back(rand_rq());
            end
            req_valid[i] = (q[i].size() > 0) && (gap[i] == 0);
            if (q[i].size() > 0) begin
                req_we[i]            = q[i][0].we;
                req_addr[i*AW +: AW] = q[i][0].addr;
                req_wdata[i*DW +: DW] = q[i][0].data;
            end else begin
                req_we[i]            = 1'($urandom);
                req_addr[i*AW +: AW] = AW'($urandom);
                req_wdata[i*DW +: DW] = DW'($urandom);
            end
        end

        // Reference: grant only when bus free; first valid requester in rr order.
        g = -1;
        rdy_exp = '0;
        nv = $countones(req_valid);
        if (rst_n && cyc >= free_at) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
            end
        end
        if (g >= 0) begin
            rq_t r;
            int last;
            r = q[g][0];
            rdy_exp[g] = 1'b1;
            e_wen[cyc+1]  = r.we;
            e_rstb[cyc+1] = !r.we;
            last = r.we ? cyc + 2 : cyc + RD + 2;
            for (int k = cyc + 1; k <= last; k++) begin
                e_busy[k]  = 1'b1;
                e_addr[k]  = r.addr;
                e_wdata[k] = r.data;
                e_wchk[k]  = r.we;
            end
            e_rsp[last] = N'(1) << g;
            if (r.we) begin
                mmem[r.addr] = r.data;
            end else begin
                e_rdchk[last] = 1'b1;
                e_rdata[last] = mmem.exists(r.addr) ? mmem[r.addr] : dflt(r.addr);
                rd_lo = cyc + 2;
                rd_hi = cyc + RD + 1;
            end
            free_at = last + 1;
            rr = (g + 1) % N;
        end
        if (!rst_n) begin
            for (int k = cyc + 1; k <= cyc + RD + 4; k++) begin
                e_wen[k] = 0; e_rstb[k] = 0; e_busy[k] = 0;
                e_rdchk[k] = 0; e_wchk[k] = 0; e_rsp[k] = '0;
            end
            rr = 0;
            free_at = cyc + 1;
        end

        #4;
        chk("req_ready", 64'(req_ready), 64'(rdy_exp));
        chk("gb_wen",    64'(gb_wen),    64'(e_wen[cyc]));
        chk("gb_rstb",   64'(gb_rstb),   64'(e_rstb[cyc]));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp[cyc]));
        chk("busy",      64'(busy),      64'(e_busy[cyc]));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdchk[cyc] ? e_rdata[cyc] : m_last));
        if (e_busy[cyc]) chk("gb_addr", 64'(gb_addr), 64'(e_addr[cyc]));
        if (e_wchk[cyc]) chk("gb_wdata", 64'(gb_wdata), 64'(e_wdata[cyc]));
`ifdef GB_ARB_STATS_EN
        chk("stat_xact",    64'(stat_xact),    64'(m_xact));
        chk("stat_contend", 64'(stat_contend), 64'(m_cont));
`endif
        if (e_rdchk[cyc]) m_last = e_rdata[cyc];
        if (e_rsp[cyc] != '0) m_xact++;
        if (g >= 0 && nv > 1) m_cont++;
        if (!rst_n) begin
            m_last = '0; m_xact = 0; m_cont = 0;
        end

        if (gb_wen) smem[gb_addr] = gb_wdata;
        if (gb_rstb) begin
            srd_t s;
            s.t = cyc; s.a = gb_addr;
            s_q.push_back(s);
        end
        if (g >= 0) begin
            q[g].delete(0);
            if (rand_mode) gap[g] = $urandom_range(0, 3);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        int nrst;
        int dc;
        for (int k = 0; k < MAXC; k++) begin
            e_rsp[k] = '0; e_addr[k] = '0; e_wdata[k] = '0; e_rdata[k] = '0;
        end
        for (int i = 0; i < N; i++) gap[i] = 0;
        mmem[AW'(0)] = 32'hCC;
        smem[AW'(0)] = 32'hCC;

        // Reset held with every requester asserting valid.
        rst_req = 1'b0;
        q[0].push_back(mk(1'b0, AW'(24'h10), '0));
        q[1].push_back(mk(1'b1, AW'(24'h14), 32'h1234));
        run(4);
        chk("rst_gb_addr",  64'(gb_addr),  64'(0));
        chk("rst_gb_wdata", 64'(gb_wdata), 64'(0));
        chk("rst_rdata",    64'(rsp_rdata), 64'(0));
        rst_req = 1'b1;
        run(12);

        // Single write, single read, write-then-read through the other requester.
        q[0].push_back(mk(1'b1, AW'(24'h4), 32'h5));
        run(6);
        q[0].push_back(mk(1'b0, AW'(24'h0), '0));
        run(9);
        q[0].push_back(mk(1'b1, AW'(24'h20), 32'hD0));
        run(1);
        q[1].push_back(mk(1'b0, AW'(24'h20), '0));
        run(12);

        // Both requesters reading back-to-back: strict alternation.
        for (int k = 0; k < 6; k++) begin
            q[0].push_back(mk(1'b0, AW'(k * 4), '0));
            q[1].push_back(mk(1'b0, AW'(k * 4 + 32), '0));
        end
        run(80);

        // Random traffic with resets landing inside a read wait window.
        rand_mode = 1'b1;
        hold = 0;
        nrst = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold > 0) begin
                rst_req = 1'b0;
                hold--;
            end else begin
                rst_req = 1'b1;
                if (nrst < 3 && k >= 300 * (nrst + 1) && cyc + 1 >= rd_lo && cyc + 1 <= rd_hi) begin
                    rst_req = 1'b0;
                    hold = 2;
                    nrst++;
                end
            end
            step();
        end
        rst_req = 1'b1;
        chk("rst_in_wait_seen", 64'(nrst > 0), 64'(1));

        rand_mode = 1'b0;
        dc = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || cyc < free_at + 1) && dc < 200) begin
            step();
            dc++;
        end
        chk("drain", 64'(dc < 200), 64'(1));
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
